io_program_loader: RTL

// - Upstream feeder of the cache controller's IO port.
// - Takes a UART RX byte stream, assembles little-endian 32-bit words, and writes

---
 rtl/io_program_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/io_program_loader.sv
// UART-fed image loader: assembles LE 32-bit words and writes them to DDR via the cache IO port.
// Latency: word write issued the cycle after its 4th byte; io_we drops the cycle after io_data_valid.
// Backpressure: rx_ready low outside LEN/DATA/CSUM, so bytes wait during WRITE. Option: IO_LOADER_CHECKSUM_EN.
module io_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MAX_WORDS = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        io_init_complete,
  output logic [31:0] io_addr,
  output logic [31:0] io_din,
  output logic        io_we,
  input  logic        io_data_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef IO_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_WAIT_INIT, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_WAIT_INIT, S_LEN, S_DATA, S_WRITE, S_DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] n_q, n_d;
  logic [31:0] idx_q, idx_d;
  logic        rx_ready_q, rx_ready_d;
  logic [31:0] io_addr_q, io_addr_d;
  logic [31:0] io_din_q, io_din_d;
  logic        io_we_q, io_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef IO_LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        byte_fire;
  logic [31:0] word_nxt;
  logic [31:0] idx_inc;
  state_t      after_last;

  assign byte_fire = rx_valid && rx_ready_q;
  // Shift in from the top so the first (least significant) byte lands in [7:0] after four bytes.
  assign word_nxt  = {rx_data, word_q[31:8]};
  assign idx_inc   = idx_q + 32'd1;
`ifdef IO_LOADER_CHECKSUM_EN
  assign after_last = S_CSUM;
`else
  assign after_last = S_DONE;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    n_d        = n_q;
    idx_d      = idx_q;
    io_addr_d  = io_addr_q;
    io_din_d   = io_din_q;
    io_we_d    = io_we_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IO_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_WAIT_INIT: begin
        if (io_init_complete) begin
          state_d = S_LEN;
          busy_d  = 1'b1;
        end
      end
      S_LEN: begin
        if (byte_fire) begin
          word_d = word_nxt;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            n_d   = word_nxt;
            idx_d = 32'd0;
            if (word_nxt == 32'd0) begin
              state_d = after_last;
            end else if (word_nxt > MAX_WORDS) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (byte_fire) begin
          word_d = word_nxt;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = S_WRITE;
            io_we_d   = 1'b1;
            io_addr_d = BASE_ADDR + {idx_q[29:0], 2'b00};
            io_din_d  = word_nxt;
          end
        end
      end
      S_WRITE: begin
        if (io_data_valid) begin
          io_we_d = 1'b0;
          idx_d   = idx_inc;
`ifdef IO_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ io_din_q;
`endif
          state_d = (idx_inc < n_q) ? S_DATA : after_last;
        end
      end
`ifdef IO_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (byte_fire) begin
          word_d = word_nxt;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_DONE;
            if (word_nxt != csum_q) err_d = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // Outputs are registered from the next state, so they line up with the state they describe.
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA)
`ifdef IO_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    if (state_d == S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_WAIT_INIT;
      cnt_q      <= 2'd0;
      word_q     <= 32'd0;
      n_q        <= 32'd0;
      idx_q      <= 32'd0;
      rx_ready_q <= 1'b0;
      io_addr_q  <= 32'd0;
      io_din_q   <= 32'd0;
      io_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IO_LOADER_CHECKSUM_EN
      csum_q     <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      rx_ready_q <= rx_ready_d;
      io_addr_q  <= io_addr_d;
      io_din_q   <= io_din_d;
      io_we_q    <= io_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IO_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign io_addr  = io_addr_q;
  assign io_din   = io_din_q;
  assign io_we    = io_we_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
